d_mem_sized: RTL and testbench

Parametrised successor to the single-cycle word data memory in the MIPS datapath. It adds byte, halfword and word loads/stores, signed/unsigned load extension, and a req/ready handshake with a configurable number of wait states. It also adds alignment and range error reporting. It sits between the ALU address output and the writeBack mux, and is driven by the control unit's load/store decode.

---
 rtl/d_mem_sized.sv | 191 +++++++++++++++++++
 tb/tb_d_mem_sized.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_sized.sv
// Sized data memory: byte/half/word loads and stores with a req/ready handshake,
// a configurable number of wait states, and alignment/range error reporting.
module d_mem_sized #(
  parameter int MEM_DEPTH = 256,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        busy,
  output logic        err_align,
  output logic        err_range
);
  localparam int         IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d, sext_q, sext_d;
  logic        ready_q, ready_d, busy_q, busy_d, ea_q, ea_d, er_q, er_d;

  logic [31:0]      mem_q [MEM_DEPTH];
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      word_s, load_s, wr_data_s;
  logic [15:0]      half_s;
  logic [7:0]       byte_s;
  logic [3:0]       wr_be_s;
  logic             align_err_s, range_err_s, mem_we_s;

  assign idx_s  = addr_q[IDX_W+1:2];
  assign word_s = mem_q[idx_s];

  // Error classification of the captured request; the range check uses the full word index.
  always_comb begin
    align_err_s = 1'b0;
    case (size_q)
      2'b00:   align_err_s = 1'b0;
      2'b01:   align_err_s = addr_q[0];
      2'b10:   align_err_s = |addr_q[1:0];
      default: align_err_s = 1'b1;
    endcase
    range_err_s = ({2'b00, addr_q[31:2]} >= 32'(MEM_DEPTH));
  end

  // Little-endian lane extraction for loads and byte-enable merge data for stores.
  always_comb begin
    byte_s    = word_s[{addr_q[1:0], 3'b000} +: 8];
    half_s    = addr_q[1] ? word_s[31:16] : word_s[15:0];
    load_s    = word_s;
    wr_be_s   = 4'b0000;
    wr_data_s = wdata_q;
    case (size_q)
      2'b00: begin
        load_s    = sext_q ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
        wr_be_s   = 4'b0001 << addr_q[1:0];
        wr_data_s = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        load_s    = sext_q ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
        wr_be_s   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data_s = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        load_s    = word_s;
        wr_be_s   = 4'b1111;
        wr_data_s = wdata_q;
      end
      default: begin
        load_s    = 32'h0000_0000;
        wr_be_s   = 4'b0000;
        wr_data_s = wdata_q;
      end
    endcase
  end

  // Handshake FSM: next state, request capture and registered output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    we_d     = we_q;
    sext_d   = sext_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;
    ea_d     = 1'b0;
    er_d     = 1'b0;
    mem_we_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (req) begin
          addr_d  = address;
          wdata_d = writeData;
          size_d  = size;
          we_d    = we;
          sext_d  = sign_ext;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          ready_d  = 1'b1;
          ea_d     = align_err_s;
          er_d     = range_err_s;
          mem_we_s = we_q & ~align_err_s & ~range_err_s;
          if (align_err_s || range_err_s) begin
            rdata_d = 32'h0000_0000;
          end else if (!we_q) begin
            rdata_d = load_s;
          end else begin
            rdata_d = rdata_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, captured request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      rdata_q <= 32'h0000_0000;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      ea_q    <= 1'b0;
      er_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sext_q  <= sext_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      ea_q    <= ea_d;
      er_q    <= er_d;
    end
  end

  // RAM array is never reset; a reset mid-access leaves the FSM idle so no write fires.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_s[b]) begin
          mem_q[idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

  assign readData  = rdata_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign err_align = ea_q;
  assign err_range = er_q;
endmodule

// File: tb/tb_d_mem_sized.sv
// Directed bench for d_mem_sized: one instance with LATENCY=1, one with LATENCY=4.
module tb_d_mem_sized;
  logic        clk = 1'b0;
  logic        rst1_n = 1'b1, rst4_n = 1'b1;
  logic        req1 = 1'b0, req4 = 1'b0;
  logic        we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] address = 32'h0, writeData = 32'h0;
  logic [31:0] rd1, rd4;
  logic        rdy1, rdy4, busy1, busy4, ea1, ea4, er1, er4;
  int          vectors = 0, miscompares = 0;

  logic [31:0] rd;
  logic        ea, er;
  int          lat;

  always #5 clk = ~clk;

  d_mem_sized #(.MEM_DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .req(req1), .we(we), .size(size), .sign_ext(sign_ext),
    .address(address), .writeData(writeData), .readData(rd1), .ready(rdy1), .busy(busy1),
    .err_align(ea1), .err_range(er1));

  d_mem_sized #(.MEM_DEPTH(256), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .req(req4), .we(we), .size(size), .sign_ext(sign_ext),
    .address(address), .writeData(writeData), .readData(rd4), .ready(rdy4), .busy(busy4),
    .err_align(ea4), .err_range(er4));

  // Issue one request and wait (bounded) for its ready pulse; lat counts edges after accept.
  task automatic access(input bit s4, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] r, output logic e_a, output logic e_r, output int l);
    @(negedge clk);
    we = w; size = sz; sign_ext = sx; address = a; writeData = wd;
    if (s4) req4 = 1'b1; else req1 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0; req4 = 1'b0;
    l = 0; r = 32'h0; e_a = 1'b0; e_r = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (s4 ? rdy4 : rdy1) begin
        l = i;
        r = s4 ? rd4 : rd1;
        e_a = s4 ? ea4 : ea1;
        e_r = s4 ? er4 : er1;
        break;
      end
    end
    if (l == 0) begin
      $display("FAIL timeout: no ready for addr %h", a);
      miscompares++; vectors++;
    end
  endtask

  task automatic test_reset();
    #2 rst1_n = 1'b0; rst4_n = 1'b0;
    #1;
    if ({rd1, rdy1, busy1, ea1, er1} !== 36'h0) begin
      $display("FAIL reset1: got %h want 0", {rd1, rdy1, busy1, ea1, er1}); miscompares++;
    end
    vectors++;
    if ({rd4, rdy4, busy4, ea4, er4} !== 36'h0) begin
      $display("FAIL reset4: got %h want 0", {rd4, rdy4, busy4, ea4, er4}); miscompares++;
    end
    vectors++;
    repeat (2) @(negedge clk);
    rst1_n = 1'b1; rst4_n = 1'b1;
  endtask

  task automatic test_word();
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, ea, er, lat);
    if ({lat, ea, er} !== {32'd1, 2'b00}) begin
      $display("FAIL store_word: lat/ea/er got %0d/%b/%b want 1/0/0", lat, ea, er); miscompares++;
    end
    vectors++;
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, ea, er, lat);
    if ({rd, lat, ea, er} !== {32'hDEADBEEF, 32'd1, 2'b00}) begin
      $display("FAIL load_word: got %h lat %0d ea %b er %b want deadbeef lat 1", rd, lat, ea, er);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_merge();
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, ea, er, lat);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, rd, ea, er, lat);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, rd, ea, er, lat);
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, ea, er, lat);
    if (rd !== 32'hBEEFAA44) begin
      $display("FAIL merge: got %h want beefaa44", rd); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_extension();
    logic [1:0]  szs [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    logic        sxs [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] ads [6] = '{32'h30, 32'h30, 32'h30, 32'h30, 32'h31, 32'h32};
    logic [31:0] exp [6] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0,
                             32'h000080F0, 32'hFFFFFF80, 32'h00000000};
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h000080F0, rd, ea, er, lat);
    for (int i = 0; i < 6; i++) begin
      access(1'b0, 1'b0, szs[i], sxs[i], ads[i], 32'h0, rd, ea, er, lat);
      if ({rd, ea, er} !== {exp[i], 2'b00}) begin
        $display("FAIL ext%0d: got %h ea %b er %b want %h", i, rd, ea, er, exp[i]); miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_errors();
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678, rd, ea, er, lat);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D, rd, ea, er, lat);
    access(1'b0, 1'b0, 2'b01, 1'b1, 32'h31, 32'h0, rd, ea, er, lat);
    if ({rd, ea, er} !== {32'h0, 2'b10}) begin
      $display("FAIL align_half: got %h ea %b er %b want 0 1 0", rd, ea, er); miscompares++;
    end
    vectors++;
    @(posedge clk); #1;
    if ({rdy1, ea1, er1} !== 3'b000) begin
      $display("FAIL flag_clear: got %b want 000", {rdy1, ea1, er1}); miscompares++;
    end
    vectors++;
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hBAD0BAD0, rd, ea, er, lat);
    if ({ea, er, lat} !== {2'b01, 32'd1}) begin
      $display("FAIL range_store: ea %b er %b lat %0d want 0 1 1", ea, er, lat); miscompares++;
    end
    vectors++;
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, rd, ea, er, lat);
    if (rd !== 32'hCAFEF00D) begin
      $display("FAIL last_word: got %h want cafef00d", rd); miscompares++;
    end
    vectors++;
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, ea, er, lat);
    if (rd !== 32'h12345678) begin
      $display("FAIL word0_nowrap: got %h want 12345678", rd); miscompares++;
    end
    vectors++;
    access(1'b0, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, rd, ea, er, lat);
    if ({rd, ea, er} !== {32'h0, 2'b10}) begin
      $display("FAIL size11: got %h ea %b er %b want 0 1 0", rd, ea, er); miscompares++;
    end
    vectors++;
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h80000000, 32'h0, rd, ea, er, lat);
    if ({ea, er} !== 2'b01) begin
      $display("FAIL range_high: ea %b er %b want 0 1", ea, er); miscompares++;
    end
    vectors++;
    access(1'b0, 1'b0, 2'b11, 1'b0, 32'h401, 32'h0, rd, ea, er, lat);
    if ({ea, er} !== 2'b11) begin
      $display("FAIL both_err: ea %b er %b want 1 1", ea, er); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_reset_mid();
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h50, 32'h00000055, rd, ea, er, lat);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, rd, ea, er, lat);
    if ({rd, lat} !== {32'h55, 32'd4}) begin
      $display("FAIL lat4_load: got %h lat %0d want 55 lat 4", rd, lat); miscompares++;
    end
    vectors++;
    @(negedge clk);
    we = 1'b1; size = 2'b10; address = 32'h50; writeData = 32'hAAAAAAAA; req4 = 1'b1;
    @(posedge clk); #1;
    req4 = 1'b0;
    @(posedge clk); #1;
    rst4_n = 1'b0;
    #1;
    if ({rd4, rdy4, busy4, ea4, er4} !== 36'h0) begin
      $display("FAIL mid_reset: got %h want 0", {rd4, rdy4, busy4, ea4, er4}); miscompares++;
    end
    vectors++;
    @(negedge clk);
    rst4_n = 1'b1;
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, rd, ea, er, lat);
    if (rd !== 32'h55) begin
      $display("FAIL store_discard: got %h want 55", rd); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_back_to_back();
    logic [19:0] rdy_v, busy_v, rdy_e, busy_e;
    @(negedge clk);
    we = 1'b0; size = 2'b10; address = 32'h50; req4 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      rdy_v[i-1]  = rdy4;
      busy_v[i-1] = busy4;
      rdy_e[i-1]  = (i % 5 == 0);
      busy_e[i-1] = (i % 5 != 0);
    end
    req4 = 1'b0;
    if (rdy_v !== rdy_e) begin
      $display("FAIL b2b_ready: got %b want %b", rdy_v, rdy_e); miscompares++;
    end
    vectors++;
    if (busy_v !== busy_e) begin
      $display("FAIL b2b_busy: got %b want %b", busy_v, busy_e); miscompares++;
    end
    vectors++;
    if (rd4 !== 32'h55) begin
      $display("FAIL b2b_data: got %h want 55", rd4); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_wait_freeze();
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h60, 32'h11111111, rd, ea, er, lat);
    @(negedge clk);
    we = 1'b1; size = 2'b10; address = 32'h64; writeData = 32'h22222222; req4 = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; size = 2'b00; address = 32'h60; writeData = 32'h99;
    @(posedge clk); #1;
    req4 = 1'b0;
    lat = 0;
    for (int i = 2; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdy4) begin lat = i; break; end
    end
    if (lat != 4) begin
      $display("FAIL freeze_lat: got %0d want 4", lat); miscompares++;
    end
    vectors++;
    @(posedge clk); #1;
    if (busy4 !== 1'b0) begin
      $display("FAIL dropped_req: busy got %b want 0", busy4); miscompares++;
    end
    vectors++;
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h60, 32'h0, rd, ea, er, lat);
    if (rd !== 32'h11111111) begin
      $display("FAIL freeze_60: got %h want 11111111", rd); miscompares++;
    end
    vectors++;
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h64, 32'h0, rd, ea, er, lat);
    if (rd !== 32'h22222222) begin
      $display("FAIL freeze_64: got %h want 22222222", rd); miscompares++;
    end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_merge();
    test_extension();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_wait_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
